// File: rtl/commit_packet_arbiter.sv
// commit_packet_arbiter
//   Shares one registered commit/writeback stream among NUM_INPUTS execute-unit
//   requesters. Round-robin arbitration with starvation aging; a grant is held
//   from the first beat of a multi-beat packet until its eop beat, so beats
//   from different units never interleave on the output.
// Ports
//   clk, reset               clock, synchronous active-high reset
//   valid_in/ready_in        per-input handshake (ready_in is one-hot or zero)
//   data_in                  per-input payload, input i at [i*DATAW +: DATAW]
//   sop_in/eop_in            per-input packet delimiters (only eop steers state)
//   valid_out/ready_out      registered output handshake
//   data_out/sop_out/eop_out registered beat
//   sel_out                  input index that produced the current output beat
//   locked                   high while a packet is open
module commit_packet_arbiter #(
   parameter int NUM_INPUTS   = 4,
   parameter int DATAW        = 64,
   parameter int STARVE_LIMIT = 15,
   localparam int SELW        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_INPUTS-1:0]       valid_in,
   output logic [NUM_INPUTS-1:0]       ready_in,
   input  logic [NUM_INPUTS*DATAW-1:0] data_in,
   input  logic [NUM_INPUTS-1:0]       sop_in,
   input  logic [NUM_INPUTS-1:0]       eop_in,
   output logic                        valid_out,
   input  logic                        ready_out,
   output logic [DATAW-1:0]            data_out,
   output logic                        sop_out,
   output logic                        eop_out,
   output logic [SELW-1:0]             sel_out,
   output logic                        locked
);

   localparam int CNTW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNTW-1:0] LIMIT = CNTW'(STARVE_LIMIT);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t            state, state_nxt;
   logic [SELW-1:0]   lock_id, rr_ptr, gsel;
   logic              gvalid, can_accept, fire, fire_eop;
   logic [DATAW-1:0]  dsel;
   logic              sop_sel, eop_sel;
   logic [CNTW-1:0]   cnt [NUM_INPUTS];

   assign can_accept = ~valid_out | ready_out;
   assign locked     = (state == LOCKED);

   // Grant selection: lock owner, else lowest-index starved input, else
   // first valid input at or after rr_ptr (circular).
   always_comb begin
      int              idx;
      logic            starved_hit;
      logic [SELW-1:0] sidx;
      gvalid      = 1'b0;
      gsel        = '0;
      starved_hit = 1'b0;
      idx         = 0;
      sidx        = '0;
      if (state == LOCKED) begin
         gsel   = lock_id;
         gvalid = valid_in[lock_id];
      end else begin
         gvalid = |valid_in;
         // Descending scans with overwrite leave the lowest matching index.
         for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (valid_in[i] && cnt[i] == LIMIT) begin
               starved_hit = 1'b1;
               gsel        = SELW'(i);
            end
         end
         if (!starved_hit) begin
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
               idx = int'(rr_ptr) + k;
               if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
               sidx = SELW'(idx);
               if (valid_in[sidx]) gsel = sidx;
            end
         end
      end
   end

   // Payload of the granted input.
   always_comb begin
      dsel    = '0;
      sop_sel = 1'b0;
      eop_sel = 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (gsel == SELW'(i)) begin
            dsel    = data_in[i*DATAW +: DATAW];
            sop_sel = sop_in[i];
            eop_sel = eop_in[i];
         end
      end
   end

   assign fire     = gvalid & can_accept & ~reset;
   assign fire_eop = fire & eop_sel;
   assign ready_in = fire ? ({{(NUM_INPUTS-1){1'b0}}, 1'b1} << gsel) : '0;

   // FSM: only eop decides open/close; sop is ignored so a stray sop cannot
   // reassign an open packet.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (fire) state_nxt = eop_sel ? IDLE : LOCKED;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_id <= '0;
         rr_ptr  <= '0;
      end else begin
         if (fire && !eop_sel) lock_id <= gsel;
         if (fire_eop)
            rr_ptr <= (gsel == SELW'(NUM_INPUTS - 1)) ? '0 : gsel + 1'b1;
      end
   end

   // Starvation age per input. Held (not cleared) across mid-packet beats.
   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_age
      always_ff @(posedge clk) begin
         if (reset)
            cnt[g] <= '0;
         else if (!valid_in[g] || (fire_eop && gsel == SELW'(g)))
            cnt[g] <= '0;
         else if (fire && gsel == SELW'(g))
            cnt[g] <= cnt[g];
         else if (cnt[g] != LIMIT)
            cnt[g] <= cnt[g] + 1'b1;
      end
   end

   // Output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         sop_out   <= 1'b0;
         eop_out   <= 1'b0;
         sel_out   <= '0;
      end else if (fire) begin
         valid_out <= 1'b1;
         data_out  <= dsel;
         sop_out   <= sop_sel;
         eop_out   <= eop_sel;
         sel_out   <= gsel;
      end else if (ready_out) begin
         valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_commit_packet_arbiter.sv
module tb_commit_packet_arbiter;
   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int LIM = 3;
   localparam int SW  = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    valid_in, ready_in, sop_in, eop_in;
   logic [N*DW-1:0] data_in;
   logic            valid_out, ready_out, sop_out, eop_out, locked;
   logic [DW-1:0]   data_out;
   logic [SW-1:0]   sel_out;

   typedef struct packed {
      logic [SW-1:0] sel;
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
   } beat_t;

   beat_t sb_q[$];
   beat_t cur;
   logic  ev = 1'b0;
   int    n_chk = 0, n_fail = 0;
   int    pb[N];
   int    plen[N];
   int    cyc = 0;

   commit_packet_arbiter #(.NUM_INPUTS(N), .DATAW(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
      .sop_in(sop_in), .eop_in(eop_in),
      .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
      .sop_out(sop_out), .eop_out(eop_out), .sel_out(sel_out), .locked(locked)
   );

   always #5 clk = ~clk;

   // Scoreboard: beats expected to fire are queued at the negedge before the
   // edge; just after the edge the expected output register is updated and
   // compared with the DUT.
   always @(posedge clk) begin
      logic ro_s, rst_s;
      ro_s  = ready_out;
      rst_s = reset;
      #2;
      if (rst_s) begin
         ev = 1'b0;
         sb_q.delete();
      end else if (sb_q.size() > 0) begin
         cur = sb_q.pop_front();
         ev  = 1'b1;
      end else if (ro_s) begin
         ev = 1'b0;
      end
      n_chk++;
      if (valid_out !== ev) begin
         n_fail++;
         $display("FAIL sb_valid_out t=%0t: got %b expected %b", $time, valid_out, ev);
      end else if (ev) begin
         n_chk++;
         if ({sel_out, data_out, sop_out, eop_out} !== cur) begin
            n_fail++;
            $display("FAIL sb_beat t=%0t: got sel=%0d data=%h sop=%b eop=%b expected sel=%0d data=%h sop=%b eop=%b",
                     $time, sel_out, data_out, sop_out, eop_out, cur.sel, cur.data, cur.sop, cur.eop);
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Present the current beat of each input's packet.
   task automatic drive(input logic [N-1:0] mask);
      valid_in = mask;
      for (int i = 0; i < N; i++) begin
         sop_in[i] = (pb[i] == 0);
         eop_in[i] = (pb[i] == plen[i] - 1);
         data_in[i*DW +: DW] = 32'((i << 24) | (pb[i] << 16) | (cyc & 32'hffff));
      end
   endtask

   task automatic expect_fire(input int g);
      beat_t b;
      b.sel  = SW'(g);
      b.data = data_in[g*DW +: DW];
      b.sop  = sop_in[g];
      b.eop  = eop_in[g];
      sb_q.push_back(b);
      pb[g] = (pb[g] + 1) % plen[g];
   endtask

   task automatic apply_reset();
      valid_in = '0;
      ready_out = 1'b1;
      nxt();
      reset = 1'b1;
      nxt();
      reset = 1'b0;
      for (int i = 0; i < N; i++) begin
         pb[i] = 0;
         plen[i] = 1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ready_out = 1'b1;
      drive('1);
      repeat (2) begin
         @(negedge clk);
         n_chk++;
         if (ready_in !== '0) begin
            n_fail++;
            $display("FAIL reset_ready_in: got %b expected 0000", ready_in);
         end
         nxt();
      end
      reset = 1'b0;
      valid_in = '0;
      @(negedge clk);
      n_chk++;
      if ({valid_out, data_out, sop_out, eop_out, sel_out, locked} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b d=%h s=%b e=%b sel=%0d lk=%b expected all 0",
                  valid_out, data_out, sop_out, eop_out, sel_out, locked);
      end
      nxt();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_r;
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         drive('1);
         @(negedge clk);
         exp_r = N'(1 << (k % N));
         n_chk++;
         if (ready_in !== exp_r) begin
            n_fail++;
            $display("FAIL rr_grant k=%0d: got %b expected %b", k, ready_in, exp_r);
         end
         if (k > 0) begin
            n_chk++;
            if (sel_out !== SW'((k - 1) % N)) begin
               n_fail++;
               $display("FAIL rr_sel_trail k=%0d: got %0d expected %0d", k, sel_out, (k - 1) % N);
            end
         end
         expect_fire(k % N);
         nxt();
      end
   endtask

   // Table-driven packet scenario: mask, expected grant (-1 none), expected locked.
   task automatic run_table(input string name, input int ncyc, input int vm[12],
                            input int eg[12], input int el[12]);
      logic [N-1:0] exp_r;
      for (int c = 0; c < ncyc; c++) begin
         drive(N'(vm[c]));
         @(negedge clk);
         n_chk++;
         if (locked !== el[c][0]) begin
            n_fail++;
            $display("FAIL %s_locked c=%0d: got %b expected %0d", name, c, locked, el[c]);
         end
         exp_r = (eg[c] < 0) ? '0 : N'(1 << eg[c]);
         n_chk++;
         if (ready_in !== exp_r) begin
            n_fail++;
            $display("FAIL %s_grant c=%0d: got %b expected %b", name, c, ready_in, exp_r);
         end
         if (eg[c] >= 0) expect_fire(eg[c]);
         nxt();
      end
   endtask

   task automatic test_lock();
      int vm[12], eg[12], el[12];
      apply_reset();
      plen[1] = 3;
      vm = '{1, 3, 3, 3, 14, 1, 0, 0, 0, 0, 0, 0};
      eg = '{0, 1, 1, 1, 2,  0, 0, 0, 0, 0, 0, 0};
      el = '{0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0};
      run_table("lock", 6, vm, eg, el);
   endtask

   task automatic test_starvation();
      int vm[12], eg[12], el[12];
      apply_reset();
      plen[0] = 4; plen[1] = 4; plen[2] = 4;
      vm = '{9, 9, 9, 9, 10, 10, 10, 10, 10, 12, 0, 0};
      eg = '{0, 0, 0, 0, 3,  1,  1,  1,  1,  3,  0, 0};
      el = '{0, 1, 1, 1, 0,  0,  1,  1,  1,  0,  0, 0};
      run_table("starve", 10, vm, eg, el);
   endtask

   task automatic test_stall();
      int vm[12], eg[12], el[12];
      apply_reset();
      plen[1] = 3;
      vm = '{2, 4,  4,  4,  4,  6, 6, 4, 0, 0, 0, 0};
      eg = '{1, -1, -1, -1, -1, 1, 1, 2, 0, 0, 0, 0};
      el = '{0, 1,  1,  1,  1,  1, 1, 0, 0, 0, 0, 0};
      run_table("stall", 8, vm, eg, el);
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] held;
      apply_reset();
      drive(4'b0100);
      @(negedge clk);
      n_chk++;
      if (ready_in !== 4'b0100) begin
         n_fail++;
         $display("FAIL bp_first_grant: got %b expected 0100", ready_in);
      end
      held = data_in[2*DW +: DW];
      expect_fire(2);
      nxt();
      ready_out = 1'b0;
      for (int c = 0; c < 5; c++) begin
         drive(4'b0011);
         @(negedge clk);
         n_chk++;
         if (ready_in !== '0 || valid_out !== 1'b1 || data_out !== held) begin
            n_fail++;
            $display("FAIL bp_stall c=%0d: got rdy=%b v=%b d=%h expected rdy=0000 v=1 d=%h",
                     c, ready_in, valid_out, data_out, held);
         end
         nxt();
      end
      ready_out = 1'b1;
      for (int c = 0; c < 2; c++) begin
         drive(4'b0011);
         @(negedge clk);
         n_chk++;
         if (ready_in !== N'(1 << c)) begin
            n_fail++;
            $display("FAIL bp_release c=%0d: got %b expected %b", c, ready_in, N'(1 << c));
         end
         expect_fire(c);
         nxt();
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      plen[2] = 4;
      for (int c = 0; c < 2; c++) begin
         drive(4'b0100);
         @(negedge clk);
         n_chk++;
         if (ready_in !== 4'b0100 || locked !== (c == 1)) begin
            n_fail++;
            $display("FAIL rmid_pre c=%0d: got rdy=%b lk=%b expected rdy=0100 lk=%0d",
                     c, ready_in, locked, c == 1);
         end
         expect_fire(2);
         nxt();
      end
      reset = 1'b1;
      drive(4'b0100);
      @(negedge clk);
      n_chk++;
      if (ready_in !== '0) begin
         n_fail++;
         $display("FAIL rmid_in_reset: got %b expected 0000", ready_in);
      end
      nxt();
      reset = 1'b0;
      pb[2] = 0;
      drive(4'b0101);
      @(negedge clk);
      n_chk++;
      if (locked !== 1'b0 || valid_out !== 1'b0 || ready_in !== 4'b0001) begin
         n_fail++;
         $display("FAIL rmid_after: got lk=%b v=%b rdy=%b expected lk=0 v=0 rdy=0001",
                  locked, valid_out, ready_in);
      end
      expect_fire(0);
      nxt();
      drive(4'b0101);
      @(negedge clk);
      n_chk++;
      if (ready_in !== 4'b0100) begin
         n_fail++;
         $display("FAIL rmid_restart: got %b expected 0100", ready_in);
      end
      expect_fire(2);
      nxt();
   endtask

   initial begin
      reset = 1'b1;
      valid_in = '0;
      sop_in = '0;
      eop_in = '0;
      data_in = '0;
      ready_out = 1'b1;
      for (int i = 0; i < N; i++) begin
         pb[i] = 0;
         plen[i] = 1;
      end
      test_reset();
      test_round_robin();
      test_lock();
      test_backpressure();
      test_starvation();
      test_reset_mid();
      test_stall();
      valid_in = '0;
      repeat (3) nxt();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/commit_packet_arbiter.md
# commit_packet_arbiter

Packet-aware arbiter in front of the per-issue-slot commit/writeback path. It shares one commit output stream among `NUM_INPUTS` execute-unit commit requesters. Grants are round-robin with starvation aging, and a grant is held for a multi-beat result packet (sop..eop) so that beats from different units never interleave on the writeback port. The output is registered and feeds writeback plus the committed-warp and instret tracking logic.

## Interface
- `NUM_INPUTS`, default 4: number of commit requesters (≥2).
- `DATAW`, default 64: payload width per beat, opaque to the arbiter.
- `STARVE_LIMIT`, default 15: cycles a valid, ungranted input waits before it is forced to priority (1..255).
- `SELW` (localparam) = `CLOG2(NUM_INPUTS)`.
- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `valid_in`  in  `NUM_INPUTS`  per-input beat valid.
- `ready_in`  out  `NUM_INPUTS`  per-input accept; one-hot or zero.
- `data_in`  in  `NUM_INPUTS`×`DATAW`  per-input payload.
- `sop_in`, `eop_in`  in  `NUM_INPUTS` each  per-input packet start/end flags; a single-beat packet has sop=eop=1.
- `valid_out`  out  1  registered output valid.
- `ready_out`  in  1  downstream accept.
- `data_out`  out  `DATAW`  registered payload.
- `sop_out`, `eop_out`  out  1 each  registered flags.
- `sel_out`  out  `SELW`  index of the input that produced the current output beat.
- `locked`  out  1  high while a packet is mid-flight (LOCKED state).

## Operation
- State machine has two states.
  - IDLE: no packet open.
  - LOCKED: a packet from input `lock_id` is open.
- Transitions:
  - IDLE→LOCKED: a fire on input g with eop_in[g]=0; `lock_id` becomes g.
  - LOCKED→IDLE: a fire on `lock_id` with eop=1.
  - A fire with eop=1 in IDLE stays in IDLE.
- Output slot can accept when `can_accept = ~valid_out | ready_out`.
- Grant selection is combinational, in this priority order:
  1. LOCKED: only `lock_id` is eligible. Other inputs are never granted, even if starved.
  2. IDLE with any valid input whose counter equals `STARVE_LIMIT`: the lowest-index such input.
  3. Otherwise: the first valid input scanning circularly from `rr_ptr`.
- `ready_in[g] = grant[g] & can_accept`. A fire on input i is `valid_in[i] & ready_in[i]`; at most one fire per cycle.
- On a fire, the output register loads data/sop/eop/sel from the granted input, and `valid_out` becomes 1.
- If there is no fire and `ready_out` is high, `valid_out` becomes 0. If there is no fire and `ready_out` is low, the output register holds its value.
- `rr_ptr` advances to (g+1) mod `NUM_INPUTS` only on a fire with eop=1. Mid-packet beats do not move it.
- Starve counter per input, width `CLOG2(STARVE_LIMIT+1)`:
  - Clears when `valid_in[i]`=0, or on a fire of i with eop=1.
  - Holds on a fire of i with eop=0.
  - Otherwise increments, saturating at `STARVE_LIMIT`.
- sop is passed through and never checked. A protocol violation (e.g. sop while LOCKED) must not corrupt state; behaviour is defined solely by eop.
- `locked = (state == LOCKED)`.

## Timing
- Reset values:
  - state IDLE, `lock_id` 0, `rr_ptr` 0, all counters 0.
  - `valid_out` 0, `data_out`/`sop_out`/`eop_out`/`sel_out` 0.
  - `ready_in` all 0 during reset.
- Latency: a beat fired in cycle N appears on the outputs in cycle N+1.
- Throughput: 1 beat/cycle while `ready_out`=1.
- `ready_in` depends combinationally on `ready_out`. `valid_out` has no combinational path from the inputs.
- Backpressure: while `valid_out`=1 and `ready_out`=0, all `ready_in` are 0 and the output is stable.
- Reset mid-packet: the lock is dropped and the output is flushed the next cycle. Upstream restarts from a fresh sop.
- If the locked input deasserts valid mid-packet, the arbiter stalls (no grants) until that input resumes.
- Wrap-around: when g = `NUM_INPUTS`-1, `rr_ptr` returns to 0.

## Test plan
- Single beats, with `ready_out`=1 and all four inputs valid with sop=eop=1 continuously:
  - grants go 0,1,2,3,0,… one per cycle;
  - `sel_out` trails by 1 cycle;
  - no counter reaches 15.
- Lock: input 1 sends a 3-beat packet (eop on beat 3) while input 0 stays valid:
  - outputs are 1,1,1 then 0;
  - `locked` is high for exactly 2 cycles;
  - `rr_ptr`=2 after eop.
- Backpressure: hold `ready_out`=0 for 5 cycles with `valid_out`=1:
  - `data_out` stays unchanged and all `ready_in` are 0;
  - release → the next beat is granted in the same cycle.
- Starvation, with `STARVE_LIMIT`=3: input 3 is valid while inputs 0–2 send back-to-back 4-beat packets:
  - input 3 is granted at the first IDLE cycle after its counter reaches 3;
  - it is not granted while LOCKED.
- Reset mid-packet: input 2 has sent 2 of 4 beats, then reset is asserted for 1 cycle:
  - next cycle `locked`=0, `valid_out`=0, `rr_ptr`=0;
  - input 0 can win immediately.
- Stall: input 1 is locked and drops valid for 4 cycles while input 2 is valid:
  - no grants and `valid_out` falls to 0;
  - input 1 resumes → its beat is granted.
